// File: rtl/circ_conv_pkg.sv
// Shared types, mode encodings and width helper for the convolution engine.
package circ_conv_pkg;

    // Engine sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operating modes, captured together with the operands
    localparam logic MODE_CIRC = 1'b0;
    localparam logic MODE_LIN  = 1'b1;

    // Accumulator width that cannot overflow: full product plus log2(N) growth bits
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate slice: one full-precision product per enabled cycle.
// 'sum' is the combinational acc + x*y; 'last' closes an output and restarts at zero.
module conv_mac #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    last,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod     = x * y;
    // ACC_W is always wider than the product, so the replication count is at least one
    assign prod_ext = $signed({{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod});
    assign sum      = acc_q + prod_ext;
    assign acc      = acc_q;

    // Accumulator register: cleared on reset/clr, restarted after the final tap of an output
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_q <= {ACC_W{1'b0}};
        end else if (en) begin
            if (last) begin
                acc_q <= {ACC_W{1'b0}};
            end else begin
                acc_q <= sum;
            end
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: rtl/circ_conv_engine.sv
// Sequential signed convolution engine (circular length N or linear length 2N-1)
// built around a single time-shared MAC, with a start/busy/done handshake.
module circ_conv_engine
    import circ_conv_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int ACC_W = acc_width(N, WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] a [N],
    input  logic signed [WIDTH-1:0] b [N],
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] c [2*N-1]
);

    localparam int KW = $clog2(2 * N);   // output index width, covers 0..2N-2
    localparam int JW = $clog2(N);       // tap index width, covers 0..N-1
    localparam int DW = KW + 1;          // room for k + N - j without wrap

    localparam logic [JW-1:0] J_LAST     = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST_CIR = KW'(N - 1);
    localparam logic [KW-1:0] K_LAST_LIN = KW'(2 * N - 2);

    state_t                  state_q;
    logic                    mode_q;
    logic                    busy_q;
    logic                    done_q;
    logic [KW-1:0]           k_q;
    logic [JW-1:0]           j_q;
    logic [KW-1:0]           k_last_q;
    logic signed [WIDTH-1:0] a_q [N];
    logic signed [WIDTH-1:0] b_q [N];
    logic signed [ACC_W-1:0] c_q [2*N-1];

    logic [DW-1:0]           k_ext;
    logic [DW-1:0]           j_ext;
    logic [DW-1:0]           diff;
    logic                    tap_ok;
    logic [JW-1:0]           tap_idx;
    logic signed [WIDTH-1:0] mac_x;
    logic signed [WIDTH-1:0] mac_y;
    logic                    mac_en;
    logic                    mac_clr;
    logic                    mac_last;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] mac_acc_unused;

    // Index of b for the current (k, j): wrap mod N in circular mode, zero-pad outside 0..N-1 in linear mode
    always_comb begin
        k_ext  = DW'(k_q);
        j_ext  = DW'(j_q);
        diff   = {DW{1'b0}};
        tap_ok = 1'b0;
        if (k_ext >= j_ext) begin
            diff   = k_ext - j_ext;
            tap_ok = (mode_q == MODE_CIRC) || (diff < DW'(N));
        end else begin
            diff   = k_ext + DW'(N) - j_ext;
            tap_ok = (mode_q == MODE_CIRC);
        end
        tap_idx = diff[JW-1:0];
    end

    // MAC operand selection; a forced-zero tap contributes nothing to the sum
    always_comb begin
        mac_x = a_q[j_q];
        if (tap_ok) begin
            mac_y = b_q[tap_idx];
        end else begin
            mac_y = {WIDTH{1'b0}};
        end
        mac_en   = (state_q == MAC);
        mac_clr  = (state_q == LOAD);
        mac_last = (j_q == J_LAST);
    end

    conv_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .clr   (mac_clr),
        .last  (mac_last),
        .x     (mac_x),
        .y     (mac_y),
        .acc   (mac_acc_unused),
        .sum   (mac_sum)
    );

    // Control FSM with operand capture, k/j sequencing, result write-back and registered handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= MODE_CIRC;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            k_q      <= {KW{1'b0}};
            j_q      <= {JW{1'b0}};
            k_last_q <= {KW{1'b0}};
            for (int i = 0; i < N; i++) begin
                a_q[i] <= {WIDTH{1'b0}};
                b_q[i] <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < 2*N-1; i++) begin
                c_q[i] <= {ACC_W{1'b0}};
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 2*N-1; i++) begin
                        c_q[i] <= {ACC_W{1'b0}};
                    end
                    k_q      <= {KW{1'b0}};
                    j_q      <= {JW{1'b0}};
                    k_last_q <= (mode_q == MODE_LIN) ? K_LAST_LIN : K_LAST_CIR;
                    state_q  <= MAC;
                end
                MAC: begin
                    if (j_q == J_LAST) begin
                        c_q[k_q] <= mac_sum;
                        j_q      <= {JW{1'b0}};
                        if (k_q == k_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule

// File: tb/tb_circ_conv_engine.sv
// Directed self-checking bench for circ_conv_engine (N=4, WIDTH=8, ACC_W=18).
module tb_circ_conv_engine;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               mode;
    logic signed [7:0]  a_s [4];
    logic signed [7:0]  b_s [4];
    logic               busy;
    logic               done;
    logic signed [17:0] c_s [7];

    int     checks   = 0;
    int     failures = 0;
    longint exp_c [7];

    always #5 clk = ~clk;

    circ_conv_engine #(
        .N     (4),
        .WIDTH (8),
        .ACC_W (18)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .a     (a_s),
        .b     (b_s),
        .busy  (busy),
        .done  (done),
        .c     (c_s)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("%s_c%0d", tag, k), c_s[k], exp_c[k]);
        end
    endtask

    task automatic set_basic_ops();
        a_s = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        b_s = '{8'sd1, 8'sd1, 8'sd0, 8'sd0};
    endtask

    // Start is sampled on the edge ending cycle 0; returns just after that edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, returning at the negedge of the done cycle; optional start+operand change mid-run
    task automatic wait_done(input string tag, input int exp_cyc, input int inject_cyc);
        int cyc = 0;
        int got = -1;
        while (got < 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == inject_cyc) begin
                start = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    a_s[i] = 8'sd7;
                    b_s[i] = -8'sd1;
                end
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) got = cyc;
        end
        check(tag, got, exp_cyc);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_s[i] = 8'sd0;
            b_s[i] = 8'sd0;
        end
        exp_c = '{0, 0, 0, 0, 0, 0, 0};

        // Reset for two cycles, then idle for ten
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check_c("idle");
        end

        // Circular convolution
        set_basic_ops();
        mode = 1'b0;
        pulse_start();
        wait_done("circ_done_cycle", 18, -1);
        exp_c = '{5, 3, 5, 7, 0, 0, 0};
        check_c("circ");
        @(negedge clk);
        check("circ_busy_after", busy, 1'b0);
        check("circ_done_after", done, 1'b0);

        // Linear convolution with the same operands
        mode = 1'b1;
        pulse_start();
        wait_done("lin_done_cycle", 30, -1);
        exp_c = '{1, 3, 5, 7, 4, 0, 0};
        check_c("lin");
        repeat (3) @(negedge clk);
        check("lin_hold_c4", c_s[4], 18'sd4);
        check("lin_hold_busy", busy, 1'b0);

        // Extremes: every product is +16384, four taps per output
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_s[i] = 8'sh80;
            b_s[i] = 8'sh80;
        end
        pulse_start();
        wait_done("ext_done_cycle", 18, -1);
        exp_c = '{65536, 65536, 65536, 65536, 0, 0, 0};
        check_c("ext");

        // Start while busy plus operand change after accept must be ignored
        set_basic_ops();
        mode = 1'b0;
        pulse_start();
        wait_done("busy_done_cycle", 18, 10);
        exp_c = '{5, 3, 5, 7, 0, 0, 0};
        check_c("busy");
        @(negedge clk);
        check("busy_no_restart1", busy, 1'b0);
        @(negedge clk);
        check("busy_no_restart2", busy, 1'b0);

        // Reset during MAC discards the run
        set_basic_ops();
        mode = 1'b0;
        pulse_start();
        for (int cyc = 1; cyc <= 8; cyc++) @(negedge clk);
        check("mid_c0_before", c_s[0], 18'sd5);
        check("mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy_after", busy, 1'b0);
        check("mid_done_after", done, 1'b0);
        exp_c = '{0, 0, 0, 0, 0, 0, 0};
        check_c("mid");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("mid_no_done_pulse", pulses, 0);

        // Fresh linear run after the aborted one
        mode = 1'b1;
        pulse_start();
        wait_done("post_done_cycle", 30, -1);
        exp_c = '{1, 3, 5, 7, 4, 0, 0};
        check_c("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
